mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port nibble RAM (AW-bit address, DW-bit data) between two
//  requesters (e.g. CPU datapath and a loader/debug port) with a req/gnt/done handshake.
//  Round-robin arbitration; one transaction in flight at a time.
//  Drives the RAM's chip-select, write-enable, address and write-data pins.
//  Returns read data in a register alongside done.
// PARAMETERS
//  AW  8  address width (RAM depth 2**AW)
//  DW  4  data width (nibble)
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  req0       in   1   requester 0 access request, level
//  we0        in   1   requester 0: 1 = write, 0 = read
//  addr0      in   AW  requester 0 address
//  wdata0     in   DW  requester 0 write data
//  gnt0       out  1   one-cycle pulse: requester 0 won arbitration
//  done0      out  1   one-cycle pulse: requester 0 access complete
//  req1/we1/addr1/wdata1/gnt1/done1   same as above, for requester 1
//  rdata      out  DW  read data, valid while done0|done1 after a read
//  mem_cs     out  1   RAM chip select
//  mem_we     out  1   RAM write enable
//  mem_addr   out  AW  RAM address
//  mem_wdata  out  DW  RAM write data
//  mem_rdata  in   DW  RAM read data (combinational read of mem_addr)
// BEHAVIOUR
//  - All outputs are registered. Reset (async) clears all outputs to 0.
//    Reset also sets state=IDLE and the priority pointer to 0 (requester 0 first).
//  - FSM IDLE -> ACCESS -> RESP -> IDLE. No other transitions exist except reset.
//  - IDLE, at each rising edge:
//    - no req: stay in IDLE.
//    - any req: pick a winner and go to ACCESS.
//      - only one req: that requester wins.
//      - both reqs: the requester selected by the priority pointer wins.
//    - On the same edge, latch the winner's we/addr/wdata into mem_we/mem_addr/mem_wdata.
//    - On the same edge, set mem_cs=1 and gnt<winner>=1.
//  - ACCESS: lasts exactly 1 cycle.
//    - mem_cs=1 and gnt<winner>=1 for this cycle only.
//    - RAM writes on clk falling edge inside this cycle.
//    - At the closing edge:
//      - clear mem_cs, mem_we and gnt.
//      - if read: rdata <= mem_rdata; if write: rdata holds its previous value.
//      - done<winner>=1; go to RESP.
//  - RESP: lasts exactly 1 cycle; done<winner>=1.
//    - At the closing edge: done clears, the pointer moves to the other requester, go to IDLE.
//  - Latency: req sampled at edge E0 -> mem_cs high E0..E1 -> done high E1..E2.
//    3 cycles per transaction. Both requesters continuously requesting each get
//    one access per 6 cycles, strictly alternating.
//  - we/addr/wdata are sampled only at the grant edge and may change afterwards.
//    req is ignored outside IDLE.
//  - A requester that keeps req high after done is re-arbitrated in the next IDLE.
//    It loses to a waiting peer because of the pointer.
//  - mem_addr and mem_wdata hold their last values while mem_cs=0 (don't-care to the RAM).
//  - Reset mid-transaction:
//    - mem_cs, gnt and done drop immediately (asynchronously).
//    - The access is aborted and no done is issued.
//    - A write may be lost only if reset arrives before the falling edge.
// TESTING
//  1 Reset held 3 cycles with random inputs -> all outputs 0; first grant after release goes to req0 when both request.
//  2 req0 we0=1 addr0=8'h2A wdata0=4'h9 -> next cycle gnt0=1, mem_cs=1, mem_we=1, mem_addr=2A, mem_wdata=9 for 1 cycle; done0=1 the cycle after.
//  3 Then req1 we1=0 addr1=8'h2A (RAM model) -> gnt1, mem_cs=1, mem_we=0; done1 with rdata=4'h9.
//  4 req0 and req1 held high for 24 cycles -> grant order 0,1,0,1 with 3-cycle spacing; 4 dones each; never both gnt.
//  5 reset asserted mid-ACCESS -> mem_cs/gnt drop in the same cycle; no done pulse; state IDLE; pointer=0.
//  6 req1 pulsed only during ACCESS/RESP of a requester-0 transaction -> ignored, no gnt1; addr0 changed after grant -> mem_addr unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters.
// Each transaction runs IDLE -> ACCESS -> RESP; every output is a flop.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          done0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;    // 0: requester 0 wins a tie
  logic          win_q, win_d;    // owner of the transaction in flight
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          mem_cs_q, mem_cs_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          pick;

  // A lone requester wins outright; on a tie the pointer decides.
  assign pick = req1 & (~req0 | ptr_q);

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // signal unassigned; that is what keeps this block free of latches.
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    gnt0_d      = gnt0_q;
    gnt1_d      = gnt1_q;
    done0_d     = done0_q;
    done1_d     = done1_q;
    rdata_d     = rdata_q;
    mem_cs_d    = mem_cs_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d     = ACCESS;
          win_d       = pick;
          gnt0_d      = ~pick;
          gnt1_d      = pick;
          mem_cs_d    = 1'b1;
          mem_we_d    = pick ? we1    : we0;
          mem_addr_d  = pick ? addr1  : addr0;
          mem_wdata_d = pick ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        state_d  = RESP;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        mem_cs_d = 1'b0;
        mem_we_d = 1'b0;
        done0_d  = ~win_q;
        done1_d  = win_q;
        if (!mem_we_q) rdata_d = mem_rdata;
      end
      RESP: begin
        state_d = IDLE;
        done0_d = 1'b0;
        done1_d = 1'b0;
        ptr_d   = ~win_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      win_q       <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata_q     <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      rdata_q     <= rdata_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata     = rdata_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: RAM model, grant/done scoreboard,
// a table of single transactions and hand-written multi-cycle sequences.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, addr1;
  logic [3:0] wdata0, wdata1;
  logic       gnt0, gnt1, done0, done1;
  logic [3:0] rdata;
  logic       mem_cs, mem_we;
  logic [7:0] mem_addr;
  logic [3:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(8), .DW(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
    .rdata(rdata), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM model: writes on the falling edge, combinational read.
  logic [3:0] ram [256];
  bit         ram_init;
  always @(negedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 4'h0;
      ram_init <= 1'b1;
    end else if (mem_cs && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = ram[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       who;
    logic       we;
    logic [7:0] addr;
    logic [3:0] wdata;
    logic [3:0] rdata;
  } sb_t;

  typedef struct {
    logic       r0, w0;
    logic [7:0] a0;
    logic [3:0] d0;
    logic       r1, w1;
    logic [7:0] a1;
    logic [3:0] d1;
    logic       win;
  } vec_t;

  sb_t        gq[$];
  sb_t        dq[$];
  logic [3:0] shadow [256];
  logic [3:0] last_rdata;
  int         cyc = 0;
  int         gcyc[$];
  int         gnt0_cnt = 0, gnt1_cnt = 0, done0_cnt = 0, done1_cnt = 0;

  // Expected results are computed here, at the moment the stimulus is queued.
  task automatic push_txn(input logic who, input logic we, input logic [7:0] a,
                          input logic [3:0] d, input bit with_done);
    sb_t e;
    e.who = who; e.we = we; e.addr = a; e.wdata = d;
    if (we) begin
      e.rdata   = last_rdata;
      shadow[a] = d;
    end else begin
      e.rdata    = shadow[a];
      last_rdata = shadow[a];
    end
    gq.push_back(e);
    if (with_done) dq.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever the DUT pulses gnt or done.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (gnt0 | gnt1) begin
        gcyc.push_back(cyc);
        if (gnt0) gnt0_cnt++;
        if (gnt1) gnt1_cnt++;
        check("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
        if (gq.size() == 0) begin
          check("unexpected_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        end else begin
          e = gq.pop_front();
          check("gnt_who", {31'd0, gnt1}, {31'd0, e.who});
          check("gnt_cs", {31'd0, mem_cs}, 32'd1);
          check("gnt_we", {31'd0, mem_we}, {31'd0, e.we});
          check("gnt_addr", {24'd0, mem_addr}, {24'd0, e.addr});
          if (e.we) check("gnt_wdata", {28'd0, mem_wdata}, {28'd0, e.wdata});
        end
      end
      if (done0 | done1) begin
        if (done0) done0_cnt++;
        if (done1) done1_cnt++;
        if (dq.size() == 0) begin
          check("unexpected_done", {30'd0, done1, done0}, 32'd0);
        end else begin
          e = dq.pop_front();
          check("done_who", {30'd0, done1, done0}, e.who ? 32'd2 : 32'd1);
          check("done_rdata", {28'd0, rdata}, {28'd0, e.rdata});
        end
      end
    end
  end

  task automatic drive_idle();
    req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 4'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 4'h0;
  endtask

  // One isolated transaction with exact latency checks.
  task automatic do_txn(input vec_t v);
    if (v.win) push_txn(1'b1, v.w1, v.a1, v.d1, 1'b1);
    else       push_txn(1'b0, v.w0, v.a0, v.d0, 1'b1);
    @(negedge clk);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    @(posedge clk); #1;
    check("lat_gnt", {30'd0, gnt1, gnt0}, v.win ? 32'd2 : 32'd1);
    check("lat_done_low", {30'd0, done1, done0}, 32'd0);
    @(negedge clk);
    drive_idle();
    @(posedge clk); #1;
    check("lat_done", {30'd0, done1, done0}, v.win ? 32'd2 : 32'd1);
    check("lat_cs_low", {29'd0, mem_cs, gnt1, gnt0}, 32'd0);
    @(posedge clk); #1;
    check("lat_resp_end", {29'd0, mem_cs, done1, done0}, 32'd0);
  endtask

  vec_t tbl [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = 4'h0;
    last_rdata = 4'h0;

    //             r0    w0    a0     d0    r1    w1    a1     d1    win
    tbl[0]  = '{1'b1, 1'b1, 8'h2A, 4'h9, 1'b1, 1'b1, 8'h11, 4'h3, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 8'h2A, 4'h0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 8'h2A, 4'h0, 1'b1, 1'b1, 8'h2A, 4'h6, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'h2A, 4'h7, 1'b1, 1'b1, 8'h2A, 4'h6, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 8'h2A, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'hFF, 4'hC, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 8'hFF, 4'h0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 8'h00, 4'hF, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b1};

    // Reset held three cycles under random inputs.
    reset = 1'b1;
    drive_idle();
    repeat (3) begin
      @(negedge clk);
      {req0, we0, addr0, wdata0} = 14'($urandom);
      {req1, we1, addr1, wdata1} = 14'($urandom);
      @(posedge clk); #1;
      check("reset_outputs",
            {10'd0, gnt0, gnt1, done0, done1, mem_cs, mem_we, rdata, mem_addr, mem_wdata},
            32'd0);
    end
    @(negedge clk);
    drive_idle();
    reset = 1'b0;

    for (int i = 0; i < 11; i++) do_txn(tbl[i]);

    // Both requesters held 24 cycles: strict alternation starting with 0.
    for (int k = 0; k < 4; k++) begin
      push_txn(1'b0, 1'b1, 8'h40, 4'h5, 1'b1);
      push_txn(1'b1, 1'b0, 8'h40, 4'h0, 1'b1);
    end
    gcyc.delete();
    gnt0_cnt = 0; gnt1_cnt = 0; done0_cnt = 0; done1_cnt = 0;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wdata0 = 4'h5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h40;
    repeat (24) @(posedge clk);
    @(negedge clk);
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    check("stream_gnt0", gnt0_cnt, 4);
    check("stream_gnt1", gnt1_cnt, 4);
    check("stream_done0", done0_cnt, 4);
    check("stream_done1", done1_cnt, 4);
    check("stream_grants", gcyc.size(), 8);
    for (int k = 1; k < gcyc.size(); k++) check("stream_spacing", gcyc[k] - gcyc[k-1], 3);

    // Leave the pointer at 1, then abort a requester-1 read in ACCESS.
    do_txn('{1'b1, 1'b0, 8'h40, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0});
    push_txn(1'b1, 1'b0, 8'h2A, 4'h0, 1'b0);
    @(negedge clk);
    req1 = 1'b1; addr1 = 8'h2A;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("abort_drop", {29'd0, mem_cs, gnt1, gnt0}, 32'd0);
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    last_rdata = 4'h0;
    done0_cnt = 0; done1_cnt = 0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", done0_cnt + done1_cnt, 0);
    // Pointer back at 0: requester 0 wins the tie.
    do_txn('{1'b1, 1'b0, 8'hFF, 4'h0, 1'b1, 1'b0, 8'h2A, 4'h0, 1'b0});

    // req1 only during ACCESS/RESP is ignored; addr0 moves after the grant.
    push_txn(1'b0, 1'b0, 8'h2A, 4'h0, 1'b1);
    @(negedge clk);
    req0 = 1'b1; addr0 = 8'h2A;
    @(posedge clk); #1;
    check("hold_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
    @(negedge clk);
    req0 = 1'b0; addr0 = 8'h99;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h55; wdata1 = 4'h3;
    @(posedge clk); #1;
    check("hold_addr_access", {24'd0, mem_addr}, 32'h2A);
    @(posedge clk); #1;
    check("hold_addr_resp", {24'd0, mem_addr}, 32'h2A);
    @(negedge clk);
    drive_idle();
    gnt1_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check("ignored_req1", gnt1_cnt, 0);
    check("ram_55_untouched", {28'd0, ram[8'h55]}, 32'd0);

    check("gq_empty", gq.size(), 0);
    check("dq_empty", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
